// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES-128 round-key cache.
package aes_key_pkg;

  localparam int unsigned NR_DEFAULT = 10;
  localparam int unsigned KEY_IDX_W  = 4;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } key_fsm_e;

endpackage

// File: rtl/aes_key_cache_if.sv
// Handshake between the round-key cache (master) and the key-expansion stage (slave).
interface aes_key_cache_if;

  logic                                     km_start_o;
  logic [aes_key_pkg::KEY_IDX_W-1:0]        km_rcon_o;
  aes_key_pkg::round_key_t                  km_key_o;
  aes_key_pkg::round_key_t                  km_key_rcon_i;
  logic                                     km_done_i;

  modport master (
    output km_start_o, km_rcon_o, km_key_o,
    input  km_key_rcon_i, km_done_i
  );

  modport slave (
    input  km_start_o, km_rcon_o, km_key_o,
    output km_key_rcon_i, km_done_i
  );

endinterface

// File: rtl/aes_key_cache_ram.sv
// Round-key register file: one write port, one registered read port.
// Out-of-range read addresses return zero; a read of the entry being written
// returns the previous contents.
module aes_key_cache_ram
  import aes_key_pkg::*;
#(
  parameter int unsigned DEPTH = NR_DEFAULT + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [KEY_IDX_W-1:0] waddr_i,
  input  round_key_t           wdata_i,
  input  logic [KEY_IDX_W-1:0] raddr_i,
  output round_key_t           rdata_o
);

  round_key_t mem_q [DEPTH];
  round_key_t mem_d [DEPTH];
  round_key_t rdata_q, rdata_d;

  // Next-state of the store and the read register
  always_comb begin
    mem_d   = mem_q;
    rdata_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we_i && (waddr_i == KEY_IDX_W'(i))) mem_d[i] = wdata_i;
      if (raddr_i == KEY_IDX_W'(i))           rdata_d  = mem_q[i];
    end
  end

  // Store and read register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_key_cache.sv
// AES-128 round-key cache: on each accepted cipher key, requests round keys
// 0..NR from the expansion stage one at a time, stores them, and serves them
// through a single-cycle registered read port.
// Optional watchdog: define KEY_CACHE_TIMEOUT_EN to bound each WAIT to
// TIMEOUT_CYCLES cycles and expose the sticky error_o flag.
module aes_key_cache
  import aes_key_pkg::*;
#(
  parameter int unsigned NR             = NR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  round_key_t           key_i,
  output logic                 load_ready_o,
  aes_key_cache_if.master      km,
  input  logic [KEY_IDX_W-1:0] rd_idx_i,
  output round_key_t           rd_key_o,
  output logic                 keys_valid_o,
  output logic                 busy_o
`ifdef KEY_CACHE_TIMEOUT_EN
  ,
  output logic                 error_o
`endif
);

  if (NR < 1 || NR >= (2 ** KEY_IDX_W) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("aes_key_cache: NR must be 1..%0d and TIMEOUT_CYCLES nonzero", (2 ** KEY_IDX_W) - 1);
  end

  localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NR);

  key_fsm_e             state_q, state_d;
  logic [KEY_IDX_W-1:0] idx_q, idx_d;
  round_key_t           key_q, key_d;
  logic                 start_q, start_d;
  logic                 keys_valid_q, keys_valid_d;
  logic                 busy_q, busy_d;
  logic                 load_ready_q, load_ready_d;
  logic                 store_we;

`ifdef KEY_CACHE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             error_q, error_d;
`endif

  // Fill sequencer next-state; status outputs are derived from the next state
  // so they can be registered without adding a cycle of latency.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    key_d        = key_q;
    keys_valid_d = keys_valid_q;
    store_we     = 1'b0;
`ifdef KEY_CACHE_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    error_d      = error_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_i) begin
          key_d        = key_i;
          idx_d        = '0;
          keys_valid_d = 1'b0;
          state_d      = ST_REQ;
`ifdef KEY_CACHE_TIMEOUT_EN
          error_d      = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
`ifdef KEY_CACHE_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (km.km_done_i) begin
          store_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d      = ST_DONE;
            keys_valid_d = 1'b1;
          end else begin
            idx_d   = idx_q + KEY_IDX_W'(1);
            state_d = ST_REQ;
          end
        end
`ifdef KEY_CACHE_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = ST_IDLE;
          keys_valid_d = 1'b0;
          error_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    start_d      = (state_d == ST_REQ);
    busy_d       = (state_d == ST_REQ) || (state_d == ST_WAIT);
    load_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  // Sequencer state and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      key_q        <= '0;
      start_q      <= 1'b0;
      keys_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef KEY_CACHE_TIMEOUT_EN
      wait_cnt_q   <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      key_q        <= key_d;
      start_q      <= start_d;
      keys_valid_q <= keys_valid_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
`ifdef KEY_CACHE_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      error_q      <= error_d;
`endif
    end
  end

  aes_key_cache_ram #(
    .DEPTH(NR + 1)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (store_we),
    .waddr_i(idx_q),
    .wdata_i(km.km_key_rcon_i),
    .raddr_i(rd_idx_i),
    .rdata_o(rd_key_o)
  );

  assign km.km_start_o = start_q;
  assign km.km_rcon_o  = idx_q;
  assign km.km_key_o   = key_q;
  assign keys_valid_o  = keys_valid_q;
  assign busy_o        = busy_q;
  assign load_ready_o  = load_ready_q;
`ifdef KEY_CACHE_TIMEOUT_EN
  assign error_o       = error_q;
`endif

endmodule

// File: tb/tb_aes_key_cache.sv
// Directed bench for aes_key_cache with a behavioural AES-128 key-expansion
// responder and queue-based scoreboards for request order and read data.
module tb_aes_key_cache;
  import aes_key_pkg::*;

  localparam int unsigned NR  = 10;
  localparam int unsigned TMO = 64;
  localparam round_key_t  K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam round_key_t  K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam round_key_t  K3  = 128'hffeeddccbbaa99887766554433221100;
  localparam round_key_t  K4  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 load_i;
  round_key_t           key_i;
  logic                 load_ready_o;
  logic [KEY_IDX_W-1:0] rd_idx_i;
  round_key_t           rd_key_o;
  logic                 keys_valid_o;
  logic                 busy_o;
`ifdef KEY_CACHE_TIMEOUT_EN
  logic                 error_o;
`endif

  logic        model_done, spur_done, mute;
  round_key_t  model_data, spur_data;
  int unsigned checks, errors, start_cnt, hold_idx;
  logic [7:0]  sbox_t [256];
  int unsigned exp_rcon [$];
  round_key_t  exp_rd [$];

  always #5 clk = ~clk;

  aes_key_cache_if km_if ();
  assign km_if.km_done_i     = model_done | spur_done;
  assign km_if.km_key_rcon_i = model_done ? model_data : spur_data;

  aes_key_cache #(
    .NR            (NR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_i),
    .key_i       (key_i),
    .load_ready_o(load_ready_o),
    .km          (km_if),
    .rd_idx_i    (rd_idx_i),
    .rd_key_o    (rd_key_o),
    .keys_valid_o(keys_valid_o),
    .busy_o      (busy_o)
`ifdef KEY_CACHE_TIMEOUT_EN
    ,
    .error_o     (error_o)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Round key r of the FIPS-197 AES-128 schedule for the given cipher key
  function automatic round_key_t expand(input round_key_t key, input int unsigned r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    if (r > NR) return '0;
    for (int unsigned i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int unsigned i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural expansion stage: answers each start pulse after 1..3 cycles,
  // and checks the request order against the expected-index queue.
  initial begin : responder
    int unsigned pend;
    int unsigned pr;
    int unsigned er;
    round_key_t  pk;
    pend = 0; pr = 0; pk = '0;
    model_done = 1'b0;
    model_data = '0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          model_data = expand(pk, pr);
          model_done = 1'b1;
        end
      end else if (km_if.km_start_o) begin
        start_cnt++;
        if (exp_rcon.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL km_rcon_unexpected observed=%0d expected=no request", km_if.km_rcon_o);
        end else begin
          er = exp_rcon.pop_front();
          chk("km_rcon", 128'(km_if.km_rcon_o), 128'(er));
        end
        pr = 32'(km_if.km_rcon_o);
        pk = km_if.km_key_o;
        if (!mute && pr != hold_idx) pend = $urandom_range(3, 1);
      end
    end
  end

  task automatic do_load(input round_key_t key);
    start_cnt = 0;
    for (int unsigned i = 0; i <= NR; i++) exp_rcon.push_back(i);
    load_i = 1'b1;
    key_i  = key;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!keys_valid_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_keys_valid"}, 128'(keys_valid_o), 128'(1));
  endtask

  task automatic read_sweep(input string tag, input round_key_t key, input logic zero);
    round_key_t e;
    for (int unsigned i = 0; i < 16; i++) begin
      rd_idx_i = KEY_IDX_W'(i);
      exp_rd.push_back((i <= NR && !zero) ? expand(key, i) : '0);
      @(negedge clk);
      e = exp_rd.pop_front();
      chk($sformatf("%s_rd%0d", tag, i), rd_key_o, e);
    end
  endtask

  task automatic pulse_spurious(input round_key_t data);
    spur_done = 1'b1;
    spur_data = data;
    @(negedge clk);
    spur_done = 1'b0;
  endtask

  initial begin : stimulus
    logic [7:0] inv;
    int unsigned n;
    for (int unsigned x = 0; x < 256; x++) begin
      inv = '0;
      for (int unsigned y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    checks = 0; errors = 0; start_cnt = 0; hold_idx = 99; mute = 1'b0;
    rst_n = 1'b0; load_i = 1'b0; key_i = '0; rd_idx_i = '0;
    spur_done = 1'b0; spur_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_load_ready", 128'(load_ready_o), 128'(1));
    chk("rst_km_start", 128'(km_if.km_start_o), 128'(0));
    chk("rst_km_key", km_if.km_key_o, '0);
    chk("rst_rd_key", rd_key_o, '0);
    chk("rst_keys_valid", 128'(keys_valid_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
`ifdef KEY_CACHE_TIMEOUT_EN
    chk("rst_error", 128'(error_o), 128'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Spurious completion in IDLE must not write or start anything
    pulse_spurious({4{32'hdeadbeef}});
    chk("idle_spur_busy", 128'(busy_o), 128'(0));
    read_sweep("idle_spur", '0, 1'b1);

    // Reference fill, with a load attempt in the middle that must be ignored
    do_load(K1);
    chk("k1_busy", 128'(busy_o), 128'(1));
    chk("k1_start", 128'(km_if.km_start_o), 128'(1));
    chk("k1_km_key", km_if.km_key_o, K1);
    repeat (4) @(negedge clk);
    chk("midfill_load_ready", 128'(load_ready_o), 128'(0));
    load_i = 1'b1; key_i = K2;
    @(negedge clk);
    load_i = 1'b0;
    chk("midfill_km_key", km_if.km_key_o, K1);
    wait_valid("k1");
    chk("k1_start_count", 128'(start_cnt), 128'(NR + 1));
    chk("k1_rcon_drained", 128'(exp_rcon.size()), 128'(0));
    chk("k1_done_busy", 128'(busy_o), 128'(0));
    chk("k1_done_ready", 128'(load_ready_o), 128'(1));
    rd_idx_i = 4'd1;
    @(negedge clk);
    chk("k1_fips_rk1", rd_key_o, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_idx_i = 4'd10;
    @(negedge clk);
    chk("k1_fips_rk10", rd_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_sweep("k1", K1, 1'b0);

    // Spurious completion in DONE
    pulse_spurious(~K1);
    chk("done_spur_busy", 128'(busy_o), 128'(0));
    chk("done_spur_valid", 128'(keys_valid_o), 128'(1));
    read_sweep("done_spur", K1, 1'b0);

    // Reload from DONE, with a spurious completion during REQ
    do_load(K3);
    chk("reload_valid_drop", 128'(keys_valid_o), 128'(0));
    pulse_spurious({4{32'h0badf00d}});
    wait_valid("k3");
    chk("k3_start_count", 128'(start_cnt), 128'(NR + 1));
    read_sweep("k3", K3, 1'b0);

    // Reset while waiting on round key 5
    hold_idx = 5;
    do_load(K4);
    n = 0;
    while (start_cnt < 6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("wait5_busy", 128'(busy_o), 128'(1));
    chk("wait5_rcon", 128'(km_if.km_rcon_o), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy_o), 128'(0));
    chk("midrst_ready", 128'(load_ready_o), 128'(1));
    chk("midrst_start", 128'(km_if.km_start_o), 128'(0));
    chk("midrst_rcon", 128'(km_if.km_rcon_o), 128'(0));
    chk("midrst_km_key", km_if.km_key_o, '0);
    chk("midrst_rd_key", rd_key_o, '0);
    chk("midrst_valid", 128'(keys_valid_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_rcon.delete();
    hold_idx = 99;
    @(negedge clk);
    pulse_spurious(K4);
    chk("postrst_spur_busy", 128'(busy_o), 128'(0));
    read_sweep("postrst", '0, 1'b1);

`ifdef KEY_CACHE_TIMEOUT_EN
    // Expansion stage that never answers: watchdog fires after TMO WAIT cycles
    mute = 1'b1;
    do_load(K1);
    @(negedge clk);
    n = 0;
    while (!error_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 128'(n), 128'(TMO));
    chk("tmo_error", 128'(error_o), 128'(1));
    chk("tmo_ready", 128'(load_ready_o), 128'(1));
    chk("tmo_busy", 128'(busy_o), 128'(0));
    chk("tmo_valid", 128'(keys_valid_o), 128'(0));
    mute = 1'b0;
    exp_rcon.delete();
    do_load(K2);
    chk("tmo_error_clear", 128'(error_o), 128'(0));
    wait_valid("k2");
    read_sweep("k2", K2, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_cache.md
# aes_key_cache

Round-key cache sitting directly downstream of the AES-128 key-memory/expansion stage. On each new cipher key it drives the expansion stage once per round index 0..NR and captures the returned round keys into an (NR+1)×128 store. It then serves keys to the cipher round datapath through a single-cycle registered read port. The cipher rounds therefore never wait on the iterative expansion.

## Interface
- NR, 10, number of rounds; store holds NR+1 keys, indices 0..NR
- TIMEOUT_CYCLES, 64, maximum wait per round-key request; used only when the watchdog is compiled in
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_i  in  1  new cipher key valid; accepted only when load_ready_o=1
- key_i  in  128  cipher key, sampled on the accept cycle
- load_ready_o  out  1  high in IDLE and DONE
- km_start_o  out  1  one-cycle start pulse to the expansion stage
- km_rcon_o  out  4  requested round index; stable from REQ through WAIT
- km_key_o  out  128  registered copy of the accepted cipher key; stable throughout the fill
- km_key_rcon_i  in  128  round key returned by the expansion stage
- km_done_i  in  1  expansion-stage completion pulse; km_key_rcon_i is valid in this cycle
- rd_idx_i  in  4  round-key read index
- rd_key_o  out  128  registered round key for rd_idx_i
- keys_valid_o  out  1  all NR+1 keys stored and current
- busy_o  out  1  fill in progress (REQ or WAIT)
- error_o  out  1  sticky watchdog flag; present only with the watchdog compiled in

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE/DONE, load_i=1:
  - latch key_i into km_key_o
  - clear idx to 0 and keys_valid_o to 0
  - go to REQ
- REQ: assert km_start_o for exactly one cycle with km_rcon_o=idx, then go to WAIT.
- WAIT, km_done_i=1:
  - write km_key_rcon_i into store[idx]
  - if idx==NR, go to DONE and set keys_valid_o=1
  - otherwise increment idx and go to REQ
- km_done_i outside WAIT: ignored.
- load_i while busy_o=1: ignored (load_ready_o=0). No queueing.
- Reload from DONE: keys_valid_o drops in the cycle after acceptance. Store contents are overwritten progressively.
- Read port:
  - rd_key_o <= store[rd_idx_i] on every clock, independent of state
  - rd_idx_i > NR returns 128'h0
  - reading an index while its entry is being written returns the old value (read-before-write)
- idx is 4 bits, saturating at NR; it never wraps.

## Timing
- Reset values:
  - state IDLE; idx 0
  - km_start_o 0; km_rcon_o 0; km_key_o 0
  - rd_key_o 0; keys_valid_o 0; busy_o 0; error_o 0
  - store contents: 0
- Load accepted at edge T: REQ in T+1, km_start_o high during T+1, WAIT from T+2.
- Capture edge C, where km_done_i=1 in WAIT: next REQ at C+1. After the final capture, keys_valid_o=1 at C+1.
- Minimum per-key overhead is 2 cycles plus the expansion latency.
- Read latency is 1 cycle.
- Reset asserted mid-fill: return to IDLE immediately with all outputs at reset values. A subsequent km_done_i is ignored.

## Configuration
- KEY_CACHE_TIMEOUT_EN defined:
  - a wait counter increments in WAIT and clears on REQ
  - reaching TIMEOUT_CYCLES sets error_o and returns the FSM to IDLE, with keys_valid_o=0
  - error_o clears on the next accepted load
- KEY_CACHE_TIMEOUT_EN undefined: no counter, no error_o port, and WAIT blocks indefinitely.

## Structure
- Package aes_key_pkg holds:
  - NR_DEFAULT=10
  - typedef round_key_t (128-bit)
  - FSM state enum
  - KEY_IDX_W=4
- Sub-module aes_key_cache_ram: (NR+1)×128 register file with one write port and one synchronous read port, out-of-range read returning 0.
- FSM, index counter, and watchdog live in the top module.

## Test plan
- Reset, then load key 2b7e151628aed2a6abf7158809cf4f3c with a behavioural expansion model.
  - Required: 11 km_start_o pulses with km_rcon_o=0..10.
  - Required: keys_valid_o=1 after the last capture.
  - Required: rd_idx=1 gives a0fafe1788542cb123a339392a6c7605.
  - Required: rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- load_i pulsed during fill:
  - Required: load_ready_o=0 and the load is ignored.
  - Required: stored keys match the first key only.
- Spurious km_done_i in IDLE or REQ: required no store write and no idx change.
- Reset asserted while in WAIT at idx=5: required all outputs at reset values and rd_key_o=0 for every index.
- rd_idx_i=11 and rd_idx_i=15: required rd_key_o=0 one cycle later.
- With KEY_CACHE_TIMEOUT_EN, model never returns km_done_i:
  - Required: error_o=1 exactly 64 cycles into WAIT, FSM back in IDLE.
  - Required: the next load clears error_o.
